// File: rtl/instr_sequencer.sv
// Program sequencer for the 9-bit processor: fetches ROM words, handles two-word mvi,
// drives Din/run until Done, with halt/step/breakpoint control, watchdog and opcode checks.
module instr_sequencer #(
  parameter int unsigned AW        = 8,
  parameter int unsigned ISSUE_CYC = 2,
  parameter int unsigned WDOG      = 15,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             halt_req,
  input  logic             step_mode,
  input  logic             err_clr,
  input  logic             bp_en,
  input  logic [AW-1:0]    bp_addr,
  output logic             rom_en,
  output logic [AW-1:0]    rom_addr,
  input  logic [8:0]       rom_data,
  output logic [8:0]       proc_din,
  output logic             proc_run,
  input  logic             proc_done,
  output logic [AW-1:0]    pc,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  localparam int unsigned IW = (ISSUE_CYC > 1) ? $clog2(ISSUE_CYC) : 1;
  localparam int unsigned WW = (WDOG > 1) ? $clog2(WDOG) : 1;
  localparam logic [2:0] OpMvi = 3'b001;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StIssue  = 3'd3,
    StExec   = 3'd4,
    StHalted = 3'd5,
    StError  = 3'd6
  } state_e;

  state_e        st;
  logic [8:0]    ir;
  logic [8:0]    imm;
  logic          halt_pend;
  logic          bp_skip;
  logic [IW-1:0] issue_cnt;
  logic [WW-1:0] wd_cnt;

  logic ir_mvi, dec_mvi, dec_illegal, bp_hit, issue_last, wd_expired, retire;

  assign ir_mvi      = (ir[8:6] == OpMvi);
  assign dec_mvi     = (rom_data[8:6] == OpMvi);
  assign dec_illegal = rom_data[8];
  assign bp_hit      = bp_en && (pc == bp_addr) && !bp_skip;
  assign issue_last  = (issue_cnt == IW'(ISSUE_CYC - 1));
  assign wd_expired  = (wd_cnt == WW'(WDOG - 1));
  // Done in ISSUE retires single-word ops only; for mvi it is a protocol error.
  assign retire      = proc_done && ((st == StExec) || ((st == StIssue) && !ir_mvi));

  assign proc_run = (st == StIssue) || (st == StExec);
  assign busy     = (st == StFetch) || (st == StDecode) || (st == StIssue) || (st == StExec);
  assign halted   = (st == StHalted);
  assign err      = (st == StError);
  assign state    = st;

  always_comb begin
    rom_en   = 1'b0;
    rom_addr = pc;
    if (st == StFetch) begin
      rom_en = !bp_hit;
    end else if ((st == StDecode) && dec_mvi) begin
      rom_en   = 1'b1;
      rom_addr = pc + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st          <= StIdle;
      pc          <= '0;
      instr_count <= '0;
      err_code    <= 2'd0;
      proc_din    <= 9'd0;
      ir          <= 9'd0;
      imm         <= 9'd0;
      halt_pend   <= 1'b0;
      bp_skip     <= 1'b0;
      issue_cnt   <= '0;
      wd_cnt      <= '0;
    end else begin
      if (halt_req && busy) halt_pend <= 1'b1;

      unique case (st)
        StIdle: begin
          if (start) st <= StFetch;
        end
        StFetch: begin
          if (bp_hit) begin
            st        <= StHalted;
            bp_skip   <= 1'b1;
            halt_pend <= 1'b0;
          end else begin
            bp_skip <= 1'b0;
            st      <= StDecode;
          end
        end
        StDecode: begin
          ir <= rom_data;
          if (dec_illegal) begin
            st        <= StError;
            err_code  <= 2'd1;
            halt_pend <= 1'b0;
          end else begin
            st        <= StIssue;
            issue_cnt <= '0;
            proc_din  <= rom_data;
          end
        end
        StIssue: begin
          if (ir_mvi && (issue_cnt == '0)) imm <= rom_data;
          if (proc_done && ir_mvi) begin
            st        <= StError;
            err_code  <= 2'd3;
            halt_pend <= 1'b0;
          end else if (!proc_done) begin
            if (issue_last) begin
              st     <= StExec;
              wd_cnt <= '0;
              // With a single issue cycle the immediate is still on rom_data.
              if (ir_mvi) proc_din <= (issue_cnt == '0) ? rom_data : imm;
            end else begin
              issue_cnt <= issue_cnt + IW'(1);
            end
          end
        end
        StExec: begin
          if (!proc_done) begin
            if (wd_expired) begin
              st        <= StError;
              err_code  <= 2'd2;
              halt_pend <= 1'b0;
            end else begin
              wd_cnt <= wd_cnt + WW'(1);
            end
          end
        end
        StHalted: begin
          if (start) st <= StFetch;
        end
        StError: begin
          if (err_clr) begin
            st       <= StIdle;
            err_code <= 2'd0;
          end
        end
        default: st <= StIdle;
      endcase

      if (retire) begin
        pc          <= pc + (ir_mvi ? AW'(2) : AW'(1));
        instr_count <= instr_count + CNT_W'(1);
        if (halt_pend || halt_req || step_mode) begin
          st        <= StHalted;
          halt_pend <= 1'b0;
        end else begin
          st <= StFetch;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ROM and processor models, vector table, directed corner
// sequences and randomized programs checked against an instruction-level model.
module tb_instr_sequencer;
  localparam int AW = 8, ISSUE_CYC = 2, WDOG = 15, CNT_W = 16, K = 20;
  localparam logic [8:0] MV = 9'h00a, MVI = 9'h040, ADD = 9'h080, SUB = 9'h0c8, ILL = 9'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, start, halt_req, step_mode, err_clr, bp_en;
  logic [7:0] bp_addr, rom_addr, pc;
  logic rom_en, proc_run, proc_done, busy, halted, err;
  logic [8:0] rom_data, proc_din;
  logic [1:0] err_code;
  logic [15:0] instr_count;
  logic [2:0] state;

  instr_sequencer #(.AW(AW), .ISSUE_CYC(ISSUE_CYC), .WDOG(WDOG), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .halt_req(halt_req), .step_mode(step_mode),
    .err_clr(err_clr), .bp_en(bp_en), .bp_addr(bp_addr), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .proc_din(proc_din), .proc_run(proc_run), .proc_done(proc_done),
    .pc(pc), .busy(busy), .halted(halted), .err(err), .err_code(err_code),
    .instr_count(instr_count), .state(state)
  );

  logic [8:0] rom [256];
  int lats [64];
  int run_cnt, idx, cur_lat, run_total;
  int n_chk = 0, n_fail = 0;

  // Synchronous ROM
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  // Processor: the n-th issued instruction raises Done on its lats[n]-th run cycle (0 = never)
  always @(posedge clk) begin
    if (!resetn) begin
      run_cnt <= 0;
      idx <= 0;
    end else if (proc_run) begin
      run_cnt <= run_cnt + 1;
    end else begin
      if (run_cnt != 0) idx <= idx + 1;
      run_cnt <= 0;
    end
  end
  assign cur_lat   = lats[idx[5:0]];
  assign proc_done = proc_run && (cur_lat != 0) && (run_cnt == cur_lat - 1);

  // Monitor: proc_din at the first and last cycle of every run window
  logic prev_run = 1'b0;
  logic [8:0] prev_din = 9'd0;
  logic [8:0] act_first[$], act_last[$];
  initial run_total = 0;
  always @(negedge clk) begin
    if (proc_run) run_total <= run_total + 1;
    if (proc_run && !prev_run) act_first.push_back(proc_din);
    if (!proc_run && prev_run) act_last.push_back(prev_din);
    prev_run <= proc_run;
    prev_din <= proc_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; start = 1'b0; halt_req = 1'b0; err_clr = 1'b0;
    step_mode = 1'b0; bp_en = 1'b0; bp_addr = 8'd0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int maxc);
    int c = 0;
    while (state != 3'd5 && state != 3'd6 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("wait_end_in_budget", c < maxc, 1);
  endtask

  task automatic load_rom(input logic [8:0] w0, w1, w2, w3, input int lat);
    for (int a = 0; a < 256; a++) rom[a] = ILL;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    for (int i = 0; i < 64; i++) lats[i] = lat;
  endtask

  // Instruction-level reference model
  logic [8:0] exp_first[$], exp_last[$];
  task automatic model_run(output logic [7:0] epc, output logic [15:0] ecnt,
                           output logic [1:0] ecode);
    logic [7:0] p, p1;
    logic [8:0] w;
    int k, lat;
    bit mvi;
    p = 8'd0; k = 0; ecnt = 16'd0; ecode = 2'd0;
    exp_first.delete();
    exp_last.delete();
    while (ecode == 2'd0 && k <= K) begin
      w = rom[p];
      if (w[8]) begin
        ecode = 2'd1;
      end else begin
        lat = lats[k];
        k++;
        mvi = (w[8:6] == 3'b001);
        p1 = p + 8'd1;
        exp_first.push_back(w);
        if (mvi && lat != 0 && lat <= ISSUE_CYC) begin
          ecode = 2'd3;
          exp_last.push_back(w);
        end else begin
          exp_last.push_back(mvi ? rom[p1] : w);
          if (lat == 0 || lat > ISSUE_CYC + WDOG) ecode = 2'd2;
          else begin
            p = p + (mvi ? 8'd2 : 8'd1);
            ecnt++;
          end
        end
      end
    end
    epc = p;
  endtask

  typedef struct {
    logic [8:0] w0, w1, w2, w3;
    int lat;
    logic bpen;
    logic [7:0] bpa;
    logic step;
    logic [2:0] st;
    logic [7:0] pc;
    logic [15:0] cnt;
    logic [1:0] code;
    logic ran;
  } vec_t;
  vec_t vq[$];

  initial begin
    logic [8:0] ea [10];
    logic [8:0] din_q[$];
    logic [7:0] epc;
    logic [15:0] ecnt;
    logic [1:0] ecode;
    int base, bf, bl, c, ex;

    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] ea [10];
    logic [8:0] din_q[$];
    logic [7:0] epc;
    logic [15:0] ecnt;
    logic [1:0] ecode;
    logic [2:0] op;
    int base, bf, bl, c, ex, r;

    // Reset values
    resetn = 1'b0; start = 1'b0; halt_req = 1'b0; err_clr = 1'b0;
    step_mode = 1'b0; bp_en = 1'b0; bp_addr = 8'd0;
    load_rom(ILL, ILL, ILL, ILL, 1);
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_proc_din", proc_din, 0);
    chk("rst_flags", {proc_run, rom_en, busy, halted, err}, 0);

    // Vector table: {w0..w3, lat, bp_en, bp_addr, step} -> {state, pc, count, err_code, ran}
    vq.push_back('{MVI, 9'h005, ADD, ILL, 5, 0, 0, 0, 6, 3, 2, 1, 1});
    vq.push_back('{ILL, MV, MV, MV, 5, 0, 0, 0, 6, 0, 0, 1, 0});
    vq.push_back('{MV, MV, MV, MV, 1, 0, 0, 0, 6, 4, 4, 1, 1});
    vq.push_back('{MVI, 9'h005, ADD, ILL, 2, 0, 0, 0, 6, 0, 0, 3, 1});
    vq.push_back('{MVI, 9'h005, ADD, ILL, 1, 0, 0, 0, 6, 0, 0, 3, 1});
    vq.push_back('{MV, MV, MV, MV, 17, 0, 0, 0, 6, 4, 4, 1, 1});
    vq.push_back('{MV, MV, MV, MV, 18, 0, 0, 0, 6, 0, 0, 2, 1});
    vq.push_back('{MV, MV, MV, MV, 0, 0, 0, 0, 6, 0, 0, 2, 1});
    vq.push_back('{MV, MV, MV, ILL, 3, 1, 2, 0, 5, 2, 2, 0, 1});
    vq.push_back('{MV, MV, MV, ILL, 2, 0, 0, 1, 5, 1, 1, 0, 1});
    vq.push_back('{MV, MV, MV, ILL, 2, 1, 0, 0, 5, 0, 0, 0, 0});
    vq.push_back('{SUB, ADD, MVI, 9'h1ff, 4, 0, 0, 0, 6, 4, 3, 1, 1});
    vq.push_back('{MVI, 9'h1c0, ADD, ILL, 3, 0, 0, 0, 6, 3, 2, 1, 1});
    vq.push_back('{9'h1c0, MV, MV, MV, 3, 0, 0, 0, 6, 0, 0, 1, 0});
    for (int i = 0; i < vq.size(); i++) begin
      do_reset();
      load_rom(vq[i].w0, vq[i].w1, vq[i].w2, vq[i].w3, vq[i].lat);
      bp_en = vq[i].bpen; bp_addr = vq[i].bpa; step_mode = vq[i].step;
      base = run_total;
      pulse_start();
      wait_end(400);
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), state, vq[i].st);
      chk($sformatf("vec%0d_pc", i), pc, vq[i].pc);
      chk($sformatf("vec%0d_count", i), instr_count, vq[i].cnt);
      chk($sformatf("vec%0d_err_code", i), err_code, vq[i].code);
      chk($sformatf("vec%0d_ran", i), run_total != base, vq[i].ran);
    end

    // mvi/add: start-to-run latency and proc_din trace
    do_reset();
    load_rom(MVI, 9'h005, ADD, ILL, 5);
    pulse_start();
    c = 1;
    while (!proc_run && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("start_to_run_latency", c, 3);
    c = 0;
    while (state != 3'd6 && c < 100) begin
      if (proc_run) din_q.push_back(proc_din);
      @(negedge clk);
      c++;
    end
    ea[0] = MVI; ea[1] = MVI; ea[2] = 9'h005; ea[3] = 9'h005; ea[4] = 9'h005;
    for (int i = 5; i < 10; i++) ea[i] = ADD;
    chk("din_trace_len", din_q.size(), 10);
    for (int i = 0; i < 10 && i < din_q.size(); i++)
      chk($sformatf("din_trace_%0d", i), din_q[i], ea[i]);
    chk("din_holds_after_run", proc_din, ADD);

    // Illegal opcode, start ignored in ERROR, err_clr beats start
    do_reset();
    load_rom(ILL, MV, MV, MV, 1);
    pulse_start();
    wait_end(50);
    chk("ill_err", err, 1);
    chk("ill_code", err_code, 1);
    pulse_start();
    chk("err_ignores_start", state, 6);
    err_clr = 1'b1; start = 1'b1;
    @(negedge clk);
    err_clr = 1'b0; start = 1'b0;
    chk("errclr_state", state, 0);
    chk("errclr_code", err_code, 0);
    @(negedge clk);
    chk("errclr_start_ignored", state, 0);

    // Watchdog on mv at pc=4
    do_reset();
    load_rom(MV, MV, MV, MV, 1);
    rom[4] = MV; lats[4] = 0;
    pulse_start();
    c = 0; ex = 0;
    while (state != 3'd6 && c < 300) begin
      if (state == 3'd4) ex++;
      @(negedge clk);
      c++;
    end
    chk("wdog_exec_cycles", ex, WDOG);
    chk("wdog_code", err_code, 2);
    chk("wdog_pc", pc, 4);
    chk("wdog_run", proc_run, 0);

    // Breakpoint then resume past it
    do_reset();
    load_rom(MV, MV, MV, ILL, 3);
    bp_en = 1'b1; bp_addr = 8'd2;
    pulse_start();
    wait_end(200);
    chk("bp_halted", halted, 1);
    chk("bp_pc", pc, 2);
    pulse_start();
    wait_end(200);
    chk("bp_resume_state", state, 6);
    chk("bp_resume_pc", pc, 3);
    chk("bp_resume_count", instr_count, 3);

    // Single-step
    do_reset();
    load_rom(MV, ADD, SUB, ILL, 2);
    step_mode = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      pulse_start();
      wait_end(100);
      chk($sformatf("step%0d_state", i), state, 5);
      chk($sformatf("step%0d_pc", i), pc, i);
      chk($sformatf("step%0d_count", i), instr_count, i);
    end

    // halt_req ignored in IDLE; halt_req on the retire edge
    do_reset();
    load_rom(MV, MV, ILL, ILL, 1);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    chk("idle_halt_ignored", state, 0);
    pulse_start();
    c = 0;
    while (!proc_run && c < 10) begin
      @(negedge clk);
      c++;
    end
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    wait_end(50);
    chk("halt_retire_state", state, 5);
    chk("halt_retire_pc", pc, 1);
    pulse_start();
    wait_end(100);
    chk("halt_resume_state", state, 6);
    chk("halt_resume_count", instr_count, 2);

    // Asynchronous reset during EXEC of add at pc=7
    do_reset();
    load_rom(MV, MV, MV, MV, 1);
    for (int a = 4; a < 7; a++) rom[a] = MV;
    rom[7] = ADD; lats[7] = 0;
    pulse_start();
    c = 0;
    while (!(state == 3'd4 && pc == 8'd7) && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("pre_reset_in_exec", state, 4);
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_run", proc_run, 0);
    chk("async_rst_pc", pc, 0);
    chk("async_rst_count", instr_count, 0);
    chk("async_rst_state", state, 0);

    // Randomized programs against the instruction-level model
    for (int t = 0; t < 40; t++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        r = $urandom_range(0, 99);
        op = (r < 4) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
        rom[a] = {op, 6'($urandom)};
      end
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 19);
        if (i >= K) lats[i] = 0;
        else if (r < 12) lats[i] = $urandom_range(1, 5);
        else if (r < 15) lats[i] = ISSUE_CYC + WDOG;
        else if (r == 15) lats[i] = ISSUE_CYC + WDOG + 1;
        else lats[i] = $urandom_range(3, 8);
      end
      model_run(epc, ecnt, ecode);
      bf = act_first.size();
      bl = act_last.size();
      pulse_start();
      wait_end(2000);
      @(negedge clk);
      chk($sformatf("rnd%0d_state", t), state, 6);
      chk($sformatf("rnd%0d_pc", t), pc, epc);
      chk($sformatf("rnd%0d_count", t), instr_count, ecnt);
      chk($sformatf("rnd%0d_code", t), err_code, ecode);
      chk($sformatf("rnd%0d_nissued", t), act_first.size() - bf, exp_first.size());
      chk($sformatf("rnd%0d_nended", t), act_last.size() - bl, exp_last.size());
      for (int i = 0; i < exp_first.size() && bf + i < act_first.size(); i++)
        chk($sformatf("rnd%0d_first%0d", t, i), act_first[bf + i], exp_first[i]);
      for (int i = 0; i < exp_last.size() && bl + i < act_last.size(); i++)
        chk($sformatf("rnd%0d_last%0d", t, i), act_last[bl + i], exp_last[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
